// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with tick-based debounce of press and release.
// Define KEYPAD_REPEAT_EN to build in auto-repeat strobes while a key stays pressed.
module keypad_scan #(
    parameter int SCAN_DIV     = 5000,
    parameter int DB_TICKS     = 20,
    parameter int REPEAT_TICKS = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DB_TICKS + 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;

    state_t           state_reg, state_next;
    logic [1:0]       col_idx_reg, col_idx_next;
    logic [1:0]       row_idx_reg, row_idx_next;
    logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
    logic [3:0]       key_reg, key_next;
    logic             key_valid_reg, key_valid_next;
    logic             key_held_reg, key_held_next;

    logic             any_low;
    logic [1:0]       low_idx;
    logic             row_cur;
    logic             accept;
    logic             release_done;
    logic             rpt_fire;

    assign tick    = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
    assign row_cur = row_sync_reg[row_idx_reg];

    // Lowest-index low row wins when several rows read low together.
    always_comb begin
        any_low = ~&row_sync_reg;
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_sync_reg[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign o_col[gi] = (col_idx_reg != 2'(gi));
    end

    assign o_key       = key_reg;
    assign o_key_valid = key_valid_reg;
    assign o_key_held  = key_held_reg;

    // State register together with the datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_reg  <= 4'b1111;
            row_sync_reg  <= 4'b1111;
            div_cnt_reg   <= '0;
            state_reg     <= ST_SCAN;
            col_idx_reg   <= 2'd0;
            row_idx_reg   <= 2'd0;
            db_cnt_reg    <= '0;
            key_reg       <= 4'd0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            row_meta_reg  <= i_row;
            row_sync_reg  <= row_meta_reg;
            div_cnt_reg   <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            row_idx_reg   <= row_idx_next;
            db_cnt_reg    <= db_cnt_next;
            key_reg       <= key_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
        end
    end

    // Next-state logic; nothing moves except on a scan tick.
    always_comb begin
        state_next   = state_reg;
        col_idx_next = col_idx_reg;
        row_idx_next = row_idx_reg;
        db_cnt_next  = db_cnt_reg;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    if (!any_low) begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end else begin
                        row_idx_next = low_idx;
                        if (DB_TICKS == 1) begin
                            state_next  = ST_PRESSED;
                            db_cnt_next = '0;
                            accept      = 1'b1;
                        end else begin
                            state_next  = ST_DEBOUNCE;
                            db_cnt_next = DB_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_cur) begin
                        if (db_cnt_reg == DB_W'(DB_TICKS - 1)) begin
                            state_next  = ST_PRESSED;
                            db_cnt_next = '0;
                            accept      = 1'b1;
                        end else begin
                            db_cnt_next = db_cnt_reg + DB_W'(1);
                        end
                    end else begin
                        state_next   = ST_SCAN;
                        col_idx_next = col_idx_reg + 2'd1;
                        db_cnt_next  = '0;
                    end
                end
                ST_PRESSED: begin
                    if (row_cur) begin
                        if (DB_TICKS == 1) begin
                            state_next   = ST_SCAN;
                            col_idx_next = col_idx_reg + 2'd1;
                            db_cnt_next  = '0;
                            release_done = 1'b1;
                        end else begin
                            state_next  = ST_RELEASE;
                            db_cnt_next = DB_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (row_cur) begin
                        if (db_cnt_reg == DB_W'(DB_TICKS - 1)) begin
                            state_next   = ST_SCAN;
                            col_idx_next = col_idx_reg + 2'd1;
                            db_cnt_next  = '0;
                            release_done = 1'b1;
                        end else begin
                            db_cnt_next = db_cnt_reg + DB_W'(1);
                        end
                    end else begin
                        state_next  = ST_PRESSED;
                        db_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);

    logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;

    // Counts ticks spent in PRESSED; any exit (including a bounce into RELEASE) restarts it.
    always_comb begin
        rpt_cnt_next = rpt_cnt_reg;
        rpt_fire     = 1'b0;
        if (state_reg != ST_PRESSED) begin
            rpt_cnt_next = '0;
        end else if (tick) begin
            if (row_cur) begin
                rpt_cnt_next = '0;
            end else if (rpt_cnt_reg == RPT_W'(REPEAT_TICKS - 1)) begin
                rpt_cnt_next = '0;
                rpt_fire     = 1'b1;
            end else begin
                rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_reg <= '0;
        end else begin
            rpt_cnt_reg <= rpt_cnt_next;
        end
    end
`else
    assign rpt_fire = 1'b0;

    // REPEAT_TICKS has no effect unless auto-repeat is built in.
    if (REPEAT_TICKS < 1) begin : g_repeat_unused
    end
`endif

    // Output logic: strobe and key code on acceptance, re-strobe on repeat.
    always_comb begin
        key_next       = key_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;
        if (accept) begin
            key_next       = {row_idx_next, col_idx_reg};
            key_valid_next = 1'b1;
            key_held_next  = 1'b1;
        end else if (rpt_fire) begin
            key_valid_next = 1'b1;
        end
        if (release_done) begin
            key_held_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: tick-level behavioural model plus directed and random key activity.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RT = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic        o_key_held;
    logic [15:0] key_mask = 16'h0000;   // bit r*4+c set = key at row r, column c held down

    int total = 0;
    int bad   = 0;
    int nv    = 0;
    int nv0   = 0;

    logic [3:0] col_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        i_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (|(key_mask[r*4 +: 4] & ~o_col)) i_row[r] = 1'b0;
        end
    end

    keypad_scan #(
        .SCAN_DIV    (SD),
        .DB_TICKS    (DB),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_row      (i_row),
        .o_col      (o_col),
        .o_key      (o_key),
        .o_key_valid(o_key_valid),
        .o_key_held (o_key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, evaluated once per clock edge in terms of scan ticks.
    int         m_cyc = 0, m_col = 0, m_crow = 0, m_low = 0, m_high = 0, m_rpt = 0;
    bit         m_cand = 0, m_held = 0, m_valid = 0;
    logic [3:0] m_key = 4'd0, m_h0 = 4'hF, m_h1 = 4'hF;

    task m_accept();
        m_key   = 4'(m_crow * 4 + m_col);
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_cand  = 1'b0;
        m_low   = 0;
        m_high  = 0;
        m_rpt   = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_cyc = 0; m_col = 0; m_crow = 0; m_low = 0; m_high = 0; m_rpt = 0;
            m_cand = 0; m_held = 0; m_valid = 0; m_key = 4'd0; m_h0 = 4'hF; m_h1 = 4'hF;
        end else begin : m_step
            logic [3:0] seen, phys;
            bit         tk;
            for (int r = 0; r < 4; r++) phys[r] = ~key_mask[r*4 + m_col];
            seen = m_h1;
            m_h1 = m_h0;
            m_h0 = phys;
            tk = ((m_cyc % SD) == SD - 1);
            m_cyc++;
            m_valid = 1'b0;
            if (tk) begin
                if (m_held) begin
                    if (seen[m_crow]) begin
                        m_rpt = 0;
                        m_high++;
                        if (m_high >= DB) begin
                            m_held = 1'b0;
                            m_high = 0;
                            m_col  = (m_col + 1) % 4;
                        end
                    end else if (m_high > 0) begin
                        m_high = 0;
                    end else begin
                        m_rpt++;
                        if (REPEAT_ON && m_rpt == RT) begin
                            m_valid = 1'b1;
                            m_rpt   = 0;
                        end
                    end
                end else if (m_cand) begin
                    if (!seen[m_crow]) begin
                        m_low++;
                        if (m_low >= DB) m_accept();
                    end else begin
                        m_cand = 1'b0;
                        m_low  = 0;
                        m_col  = (m_col + 1) % 4;
                    end
                end else if (seen == 4'hF) begin
                    m_col = (m_col + 1) % 4;
                end else begin
                    for (int r = 3; r >= 0; r--) if (!seen[r]) m_crow = r;
                    m_cand = 1'b1;
                    m_low  = 1;
                    if (m_low >= DB) m_accept();
                end
            end
        end
    end

    // Compare process: every cycle on the falling edge, away from the active edge.
    logic [3:0] exp_col;
    initial forever begin
        @(negedge clk);
        exp_col = 4'b0001 << m_col;
        exp_col = ~exp_col;
        check("o_col", o_col, exp_col);
        check("o_key", o_key, m_key);
        check("o_key_valid", o_key_valid, m_valid);
        check("o_key_held", o_key_held, m_held);
        if (o_key_valid === 1'b1) nv++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (o_key_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (o_key_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s: o_key_valid=%b expected 1 within 200 clks", name, o_key_valid);
        end
    endtask

    task automatic wait_col(input int c);
        int n = 0;
        while (o_col !== col_pat[c] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (o_col !== col_pat[c]) begin
            bad++;
            $display("FAIL wait_col: o_col=%b expected %b within 100 clks", o_col, col_pat[c]);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle scan: each column held for SD clocks, no strobes.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("idle_col", o_col, col_pat[(k / 4) % 4]);
            check("idle_valid", o_key_valid, 1'b0);
        end

        // Row 0 at column 3 low for a single tick: rejected, scan resumes at column 0.
        wait_col(2);
        wait_col(3);
        nv0 = nv;
        key_mask = 16'h0008;
        wait_clks(SD);
        key_mask = 16'h0000;
        wait_col(0);
        check("glitch_strobes", nv - nv0, 0);
        check("glitch_held", o_key_held, 1'b0);

        // Row 2 / column 1 held: one strobe, key 1001.
        nv0 = nv;
        key_mask = 16'h0200;
        wait_valid("press_valid");
        wait_clks(2 * SD);
        check("press_strobes", nv - nv0, 1);
        check("press_key", o_key, 4'b1001);
        check("press_held", o_key_held, 1'b1);

        // One-tick bounce, then a held release.
        nv0 = nv;
        key_mask = 16'h0000;
        wait_clks(SD);
        key_mask = 16'h0200;
        wait_clks(2 * SD);
        check("bounce_strobes", nv - nv0, 0);
        check("bounce_held", o_key_held, 1'b1);
        key_mask = 16'h0000;
        wait_clks(SD);
        check("release_mid_held", o_key_held, 1'b1);
        wait_clks(4 * SD);
        check("release_held", o_key_held, 1'b0);
        check("release_key", o_key, 4'b1001);
        check("release_strobes", nv - nv0, 0);

        // Reset while pressed: immediate reset values, then one fresh strobe.
        key_mask = 16'h0200;
        wait_valid("prereset_valid");
        wait_clks(SD);
        rst_n = 1'b0;
        #1;
        check("rst_col", o_col, 4'b1110);
        check("rst_key", o_key, 4'b0000);
        check("rst_valid", o_key_valid, 1'b0);
        check("rst_held", o_key_held, 1'b0);
        wait_clks(2);
        rst_n = 1'b1;
        nv0 = nv;
        wait_valid("postreset_valid");
        wait_clks(2 * SD);
        check("postreset_strobes", nv - nv0, 1);
        check("postreset_key", o_key, 4'b1001);
        key_mask = 16'h0000;
        wait_clks(6 * SD);

        // Long hold: 12 ticks after acceptance.
        nv0 = nv;
        key_mask = 16'h0200;
        wait_valid("hold_valid");
        wait_clks(12 * SD);
`ifdef KEYPAD_REPEAT_EN
        check("hold_strobes", nv - nv0, 3);
`else
        check("hold_strobes", nv - nv0, 1);
`endif
        check("hold_key", o_key, 4'b1001);
        key_mask = 16'h0000;
        wait_clks(6 * SD);

        // Random presses, multi-key overlaps, bounces and occasional resets.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] m;
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m |= 16'(1) << $urandom_range(0, 15);
            key_mask = m;
            wait_clks($urandom_range(2, 70));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                wait_clks($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            key_mask = 16'h0000;
            wait_clks($urandom_range(2, 50));
        end

        wait_clks(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
